sawtooth_period_detector: RTL and testbench



---
 rtl/sawtooth_period_detector.sv | 182 ++++++++++++++++++
 tb/tb_sawtooth_period_detector.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sawtooth_period_detector.sv
// sawtooth_period_detector: recovers the period of an 8-bit sawtooth stream from wrap-to-wrap timing.
// Optional feature macro SAWTOOTH_DET_AVG_EN: report the mean of the last four captures.
module sawtooth_period_detector #(
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned DROP_THRESHOLD = 64,
  parameter int unsigned TOLERANCE      = 2,
  parameter int unsigned LOCK_MATCHES   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             sample_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   period_valid,
  output logic                   locked,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  localparam int unsigned            MW      = (LOCK_MATCHES < 1) ? 1 : $clog2(LOCK_MATCHES + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [8:0]             DROP_TH = 9'(DROP_THRESHOLD);
  localparam logic [COUNT_WIDTH:0]   TOL     = (COUNT_WIDTH + 1)'(TOLERANCE);
  localparam logic [MW:0]            LM      = (MW + 1)'(LOCK_MATCHES);

  state_t                 state_q, state_d;
  logic [7:0]             prev_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] last_q, last_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic [MW-1:0]          match_q, match_d;
  logic                   has_last_q, has_last_d;
  logic                   pv_q, pv_d;
  logic                   locked_q, locked_d;
  logic                   to_q, to_d;

  logic                   wrap, meas, cap, sat, is_match, lock_hit;
  logic [8:0]             drop;
  logic [COUNT_WIDTH:0]   cnt_x, last_x, absdiff;
  logic [MW:0]            match_inc;

  assign drop = {1'b0, prev_q} - {1'b0, sample_in};
  assign wrap = (prev_q > sample_in) && (drop >= DROP_TH);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= SEEK;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEEK: begin
        if (wrap) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (sat)           state_d = SEEK;
        else if (lock_hit) state_d = TRACK;
      end
      TRACK: begin
        if (sat)                   state_d = SEEK;
        else if (cap && !is_match) state_d = ACQUIRE;
      end
      default: state_d = SEEK;
    endcase
  end

  // FSM: decoded per-cycle events; a wrap on the saturating cycle beats the timeout
  always_comb begin
    meas = (state_q != SEEK);
    cap  = meas && wrap;
    sat  = meas && !wrap && (cnt_q == CNT_MAX);
  end

  // Period comparison widened by one bit so the difference never wraps
  always_comb begin
    cnt_x     = {1'b0, cnt_q};
    last_x    = {1'b0, last_q};
    absdiff   = (cnt_x >= last_x) ? (cnt_x - last_x) : (last_x - cnt_x);
    is_match  = (absdiff <= TOL);
    match_inc = {1'b0, match_q} + 1'b1;
    lock_hit  = cap && has_last_q && is_match && (match_inc >= LM);
  end

  always_comb begin
    cnt_d      = cnt_q;
    match_d    = match_q;
    last_d     = last_q;
    has_last_d = has_last_q;
    if (wrap)      cnt_d = CNT_ONE;
    else if (sat)  cnt_d = '0;
    else if (meas) cnt_d = cnt_q + 1'b1;
    if (sat) begin
      match_d    = '0;
      has_last_d = 1'b0;
    end else if (cap) begin
      last_d     = cnt_q;
      has_last_d = 1'b1;
      if (has_last_q) begin
        if (!is_match)          match_d = '0;
        else if (match_inc <= LM) match_d = match_inc[MW-1:0];
      end
    end
    locked_d = (state_d == TRACK);
    to_d     = sat;
  end

`ifdef SAWTOOTH_DET_AVG_EN
  logic [2:0][COUNT_WIDTH-1:0] hist_q, hist_d;
  logic [2:0]                  ncap_q, ncap_d;
  logic [COUNT_WIDTH+1:0]      sum;

  // The newest capture plus the three before it form the averaging window
  always_comb begin
    hist_d = hist_q;
    ncap_d = ncap_q;
    sum    = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]} + {2'b00, cnt_q};
    if (sat) begin
      ncap_d = '0;
    end else if (cap) begin
      hist_d[2] = hist_q[1];
      hist_d[1] = hist_q[0];
      hist_d[0] = cnt_q;
      if (ncap_q != 3'd4) ncap_d = ncap_q + 1'b1;
    end
    pv_d     = cap && (ncap_q >= 3'd3);
    period_d = pv_d ? sum[COUNT_WIDTH+1:2] : period_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      ncap_q <= '0;
    end else begin
      hist_q <= hist_d;
      ncap_q <= ncap_d;
    end
  end
`else
  always_comb begin
    pv_d     = cap;
    period_d = cap ? cnt_q : period_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      period_q   <= '0;
      match_q    <= '0;
      has_last_q <= 1'b0;
      pv_q       <= 1'b0;
      locked_q   <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      prev_q     <= sample_in;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      period_q   <= period_d;
      match_q    <= match_d;
      has_last_q <= has_last_d;
      pv_q       <= pv_d;
      locked_q   <= locked_d;
      to_q       <= to_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_sawtooth_period_detector.sv
// Directed-vector bench for sawtooth_period_detector (default build; SAWTOOTH_DET_AVG_EN runs the averaging test).
module tb_sawtooth_period_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sample_in = '0;
  logic [15:0] period;
  logic        period_valid, locked, timeout;

  int vectors = 0;
  int errors  = 0;

  sawtooth_period_detector #(
    .COUNT_WIDTH(16),
    .DROP_THRESHOLD(64),
    .TOLERANCE(2),
    .LOCK_MATCHES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_in(sample_in),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Present one sample for one cycle; outputs are then read 1 time unit after the edge.
  task automatic cyc(input logic [7:0] s);
    sample_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(8'd0);
    reset = 1'b0;
  endtask

  // Ramp index i of a P-cycle ramp is i*256/P; index dip is replaced by 168.
  task automatic ramp_seg(input int p, input int i0, input int i1, input int dip,
                          output int pv_n, output int per, output int to_n, output logic lk);
    logic [7:0] s;
    pv_n = 0;
    to_n = 0;
    for (int i = i0; i <= i1; i++) begin
      s = (i == dip) ? 8'd168 : 8'((i * 256) / p);
      cyc(s);
      if (period_valid === 1'b1) pv_n++;
      if (timeout === 1'b1) to_n++;
    end
    per = int'(period);
    lk  = locked;
  endtask

  task automatic ramp(input int p, output int pv_n, output int per, output int to_n, output logic lk);
    ramp_seg(p, 0, p - 1, -1, pv_n, per, to_n, lk);
  endtask

  task automatic lock64();
    int pv_n, per, to_n;
    logic lk;
    do_reset();
    for (int k = 0; k < 5; k++) ramp(64, pv_n, per, to_n, lk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(8'd77);
    cyc(8'd200);
    vectors++;
    if (period !== 16'd0 || period_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: period=%0d pv=%b locked=%b timeout=%b, expected all 0",
               period, period_valid, locked, timeout);
    end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    int  epv[6]  = '{0, 0, 1, 1, 1, 1};
    int  eper[6] = '{0, 0, 64, 64, 64, 64};
    bit  elk[6]  = '{0, 0, 0, 0, 1, 1};
    int  pv_n, per, to_n;
    logic lk;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ramp(64, pv_n, per, to_n, lk);
      vectors++;
      if (pv_n !== epv[k] || per !== eper[k] || lk !== elk[k] || to_n !== 0) begin
        errors++;
        $display("FAIL lock_p64 ramp%0d: pv=%0d period=%0d locked=%b timeout=%0d, expected pv=%0d period=%0d locked=%b timeout=0",
                 k, pv_n, per, lk, to_n, epv[k], eper[k], elk[k]);
      end
    end
  endtask

  task automatic test_switch();
    int  eper[5] = '{64, 128, 128, 128, 128};
    bit  elk[5]  = '{1, 0, 0, 1, 1};
    int  pv_n, per, to_n;
    logic lk;
    lock64();
    for (int k = 0; k < 5; k++) begin
      ramp(128, pv_n, per, to_n, lk);
      vectors++;
      if (pv_n !== 1 || per !== eper[k] || lk !== elk[k] || to_n !== 0) begin
        errors++;
        $display("FAIL switch_p128 ramp%0d: pv=%0d period=%0d locked=%b timeout=%0d, expected pv=1 period=%0d locked=%b timeout=0",
                 k, pv_n, per, lk, to_n, eper[k], elk[k]);
      end
    end
  endtask

  task automatic test_dip();
    int  pv_n, per, to_n;
    logic lk;
    lock64();
    for (int k = 0; k < 2; k++) begin
      ramp_seg(64, 0, 63, (k == 0) ? 51 : -1, pv_n, per, to_n, lk);
      vectors++;
      if (pv_n !== 1 || per !== 64 || lk !== 1'b1 || to_n !== 0) begin
        errors++;
        $display("FAIL dip ramp%0d: pv=%0d period=%0d locked=%b timeout=%0d, expected pv=1 period=64 locked=1 timeout=0",
                 k, pv_n, per, lk, to_n);
      end
    end
  endtask

  // Drop of exactly 64 is a wrap, drop of 63 and equal samples are not.
  task automatic test_threshold();
    int pv_n = 0;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(8'd100);
    cyc(8'd36);
    vectors++;
    if (period_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL threshold_arm: pv=%b locked=%b, expected pv=0 locked=0", period_valid, locked);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(8'd36);
      if (period_valid === 1'b1) pv_n++;
    end
    cyc(8'd99);
    if (period_valid === 1'b1) pv_n++;
    cyc(8'd36);
    if (period_valid === 1'b1) pv_n++;
    for (int i = 0; i < 8; i++) begin
      cyc(8'd100);
      if (period_valid === 1'b1) pv_n++;
    end
    vectors++;
    if (pv_n !== 0) begin
      errors++;
      $display("FAIL threshold_no_wrap: pv pulses=%0d, expected 0", pv_n);
    end
    cyc(8'd36);
    vectors++;
    if (period_valid !== 1'b1 || period !== 16'd20) begin
      errors++;
      $display("FAIL threshold_wrap: pv=%b period=%0d, expected pv=1 period=20", period_valid, period);
    end
  endtask

  task automatic test_tolerance();
    int  lens[6] = '{64, 64, 65, 63, 64, 64};
    int  epv[6]  = '{0, 0, 1, 1, 1, 1};
    int  eper[6] = '{0, 0, 64, 65, 63, 64};
    bit  elk[6]  = '{0, 0, 0, 0, 1, 1};
    int  pv_n, per, to_n;
    logic lk;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ramp(lens[k], pv_n, per, to_n, lk);
      vectors++;
      if (pv_n !== epv[k] || per !== eper[k] || lk !== elk[k] || to_n !== 0) begin
        errors++;
        $display("FAIL tolerance ramp%0d: pv=%0d period=%0d locked=%b timeout=%0d, expected pv=%0d period=%0d locked=%b timeout=0",
                 k, pv_n, per, lk, to_n, epv[k], eper[k], elk[k]);
      end
    end
  endtask

  task automatic test_mismatch();
    int  lens[7] = '{64, 64, 64, 70, 70, 70, 64};
    int  epv[7]  = '{0, 0, 1, 1, 1, 1, 1};
    int  eper[7] = '{0, 0, 64, 64, 70, 70, 70};
    bit  elk[7]  = '{0, 0, 0, 0, 0, 0, 1};
    int  pv_n, per, to_n;
    logic lk;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      ramp(lens[k], pv_n, per, to_n, lk);
      vectors++;
      if (pv_n !== epv[k] || per !== eper[k] || lk !== elk[k] || to_n !== 0) begin
        errors++;
        $display("FAIL mismatch ramp%0d: pv=%0d period=%0d locked=%b timeout=%0d, expected pv=%0d period=%0d locked=%b timeout=0",
                 k, pv_n, per, lk, to_n, epv[k], eper[k], elk[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  pv_n, per, to_n;
    logic lk;
    lock64();
    ramp_seg(64, 0, 31, -1, pv_n, per, to_n, lk);
    vectors++;
    if (pv_n !== 1 || per !== 64 || lk !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: pv=%0d period=%0d locked=%b, expected pv=1 period=64 locked=1", pv_n, per, lk);
    end
    reset = 1'b1;
    cyc(8'd128);
    reset = 1'b0;
    vectors++;
    if (period !== 16'd0 || period_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: period=%0d pv=%b locked=%b timeout=%b, expected all 0",
               period, period_valid, locked, timeout);
    end
    ramp_seg(64, 33, 63, -1, pv_n, per, to_n, lk);
    ramp(64, pv_n, per, to_n, lk);
    vectors++;
    if (pv_n !== 0 || per !== 0 || lk !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_arm: pv=%0d period=%0d locked=%b, expected pv=0 period=0 locked=0", pv_n, per, lk);
    end
    ramp(64, pv_n, per, to_n, lk);
    vectors++;
    if (pv_n !== 1 || per !== 64 || lk !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_first: pv=%0d period=%0d locked=%b, expected pv=1 period=64 locked=0", pv_n, per, lk);
    end
  endtask

  task automatic test_timeout();
    int  pv_n, per, to_n;
    int  pulses = 0;
    logic lk;
    do_reset();
    for (int k = 0; k < 3; k++) ramp(64, pv_n, per, to_n, lk);
    cyc(8'd100);
    vectors++;
    if (period_valid !== 1'b1 || period !== 16'd64) begin
      errors++;
      $display("FAIL timeout_last_wrap: pv=%b period=%0d, expected pv=1 period=64", period_valid, period);
    end
    for (int i = 0; i < 65534; i++) begin
      cyc(8'd100);
      if (timeout === 1'b1 || period_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL timeout_early: pulses=%0d, expected 0", pulses);
    end
    cyc(8'd100);
    vectors++;
    if (timeout !== 1'b1 || locked !== 1'b0 || period !== 16'd64 || period_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: timeout=%b locked=%b period=%0d pv=%b, expected timeout=1 locked=0 period=64 pv=0",
               timeout, locked, period, period_valid);
    end
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(8'd100);
      if (timeout === 1'b1 || period_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0 || period !== 16'd64) begin
      errors++;
      $display("FAIL timeout_after: pulses=%0d period=%0d, expected 0 pulses period=64", pulses, period);
    end
    ramp(64, pv_n, per, to_n, lk);
    vectors++;
    if (pv_n !== 0 || lk !== 1'b0 || to_n !== 0) begin
      errors++;
      $display("FAIL timeout_seek_arm: pv=%0d locked=%b timeout=%0d, expected pv=0 locked=0 timeout=0", pv_n, lk, to_n);
    end
    ramp(64, pv_n, per, to_n, lk);
    vectors++;
    if (pv_n !== 1 || per !== 64 || lk !== 1'b0) begin
      errors++;
      $display("FAIL timeout_seek_first: pv=%0d period=%0d locked=%b, expected pv=1 period=64 locked=0", pv_n, per, lk);
    end
  endtask

`ifdef SAWTOOTH_DET_AVG_EN
  task automatic test_avg();
    int  lens[6] = '{64, 64, 64, 64, 68, 64};
    int  epv[6]  = '{0, 0, 0, 0, 0, 1};
    int  eper[6] = '{0, 0, 0, 0, 0, 65};
    bit  elk[6]  = '{0, 0, 0, 0, 1, 0};
    int  pv_n, per, to_n;
    logic lk;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ramp(lens[k], pv_n, per, to_n, lk);
      vectors++;
      if (pv_n !== epv[k] || per !== eper[k] || lk !== elk[k] || to_n !== 0) begin
        errors++;
        $display("FAIL avg ramp%0d: pv=%0d period=%0d locked=%b timeout=%0d, expected pv=%0d period=%0d locked=%b timeout=0",
                 k, pv_n, per, lk, to_n, epv[k], eper[k], elk[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SAWTOOTH_DET_AVG_EN
    test_avg();
`else
    test_lock();
    test_switch();
    test_dip();
    test_threshold();
    test_tolerance();
    test_mismatch();
    test_reset_mid();
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
